f_max_scatter: RTL
==================

# f_max_scatter

Float max-pool backward unit (max-unpool / gradient scatter). It consumes the forward window elements on `in0` and locates the argmax of each window of `strideMinusOne+1` elements. During the following window it routes `in1` (the value to scatter for the completed window) to `out0` only at the argmax position, and drives zero everywhere else. It sits in the same Versat datapath as the max-accumulation units and uses the same run/running/delay/stride conventions.

## Interface
- `DATA_W`, 32, element width; IEEE-754 single-precision layout (sign in MSB)
- `DELAY_W`, 7, width of the delay, stride and position counters
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous and active-high
- `run`  in  1  one-cycle start pulse; loads the delay counter and clears window history
- `running`  in  1  datapath enable; all state except the delay counter advances only while high
- `strideMinusOne`  in  DELAY_W  window length minus one
- `delay0`  in  DELAY_W  initial delay before the first window starts
- `in0`  in  DATA_W  forward window element stream
- `in1`  in  DATA_W  scatter value for the previously completed window, presented every cycle of the current window
- `out0`  out  DATA_W  scattered output, registered, latency 1

## Operation
- Delay counter `cnt`:
  - `rst` → 0; `run` → `delay0`; else `cnt≠0` → `cnt-1`; else → `strideMinusOne`.
  - `first = (cnt==0)` marks position 0 of a window.
- Float compare `gt(a,b)` is sign-magnitude:
  - signs differ → the positive operand is greater (+0 > −0).
  - both positive → larger `[DATA_W-2:0]` is greater.
  - both negative → smaller magnitude is greater.
  - NaN is not special-cased.
- Capture path, applied when `running`:
  - `first`: `maxVal<=in0`, `maxIdx<=0`, `pos<=1`, `captured<=1`.
  - otherwise: if `gt(in0,maxVal)`, `maxVal<=in0` and `maxIdx<=pos`; `pos<=pos+1`.
  - Ties keep the earliest index.
- Window boundary, on `first` while `running`:
  - `winIdx<=maxIdx` (argmax of the completed window).
  - `hasWin<=captured`.
  - The current cycle uses `selIdx = first ? maxIdx : winIdx` combinationally.
- Scatter path, applied when `running`:
  - `curPos = first ? 0 : pos`.
  - `out0 <= (hasWinEff && curPos==selIdx) ? in1 : 0`, where `hasWinEff = first ? captured : hasWin`.
- `run` clears `captured`, `hasWin` and `pos`. The first window after `run` therefore outputs all zeros.
- When `running` is low, all datapath registers hold, including `out0`.
- `strideMinusOne=0` is a degenerate window of length 1: every window's argmax is 0, so `out0` equals the previous cycle's `in1` once `hasWin` is set.
- `strideMinusOne` must stay constant while `running`. Changing it mid-window changes the length of the next window only.

## Timing
- Reset values: `out0=0`, `cnt=0`, `maxVal=0`, `maxIdx=0`, `winIdx=0`, `pos=0`, `captured=0`, `hasWin=0`.
- `out0` latency is 1 cycle from the `in1`/position cycle.
- Scatter results for window k occupy window k+1, position-aligned.
- `rst` takes priority over `run`, and `run` takes priority over counting.
- `rst` asserted mid-window discards the partial window; the next output is zeros.
- `run` asserted together with `running`:
  - the counter loads `delay0`.
  - the history clear takes priority over the capture/scatter updates in that cycle.
  - `out0 <= 0`.

## Configuration
- `F_MAX_SCATTER_TIE_LAST_EN`:
  - defined: the capture compare is `gt(in0,maxVal) || in0==maxVal`, so ties select the latest index.
  - undefined: strict `gt`, so ties select the earliest index (default).

## Test plan
- Basic scatter. Setup: stride 4 (`strideMinusOne=3`), `delay0=0`, `run`, then `running`.
  - Stimulus: window 0 `in0` = {1.0, 3.0, 2.0, 0.5}; window 1 `in1`=7.0 constant.
  - Required: window-1 `out0` = {0, 7.0, 0, 0}, each value 1 cycle after its position.
- Sign handling. Stimulus: `in0` = {−2.0, −1.0, −3.0, −0.5}. Required: argmax index 3.
- Zero sign. Stimulus: `in0` = {−0.0, +0.0, −0.0, −0.0}. Required: argmax index 1.
- Ties. Stimulus: `in0` = {5.0, 5.0, 1.0, 5.0}. Required: index 0 without the macro, index 3 with it.
- First-window and reset behaviour.
  - After `run`, `out0` is 0 for all of window 0.
  - Asserting `rst` at window position 2 gives `out0=0` on the next cycle, and the following window outputs zeros.
- Degenerate window and stall.
  - `strideMinusOne=0`, `in1` = 1.0, 2.0, 3.0 → `out0` = 1.0, 2.0, 3.0, delayed 1 cycle.
  - Dropping `running` for 3 cycles holds `out0` and the positions.

Source files
------------

// File: rtl/f_max_scatter.sv
// f_max_scatter: float max-pool backward unit (max-unpool / gradient scatter).
// Each window of strideMinusOne+1 elements arrives on in0, and the unit finds
// its argmax. During the next window, in1 is routed to out0 only at that
// position; every other position outputs zero.
// Optional build macro F_MAX_SCATTER_TIE_LAST_EN: when defined, ties in the
// window select the latest index instead of the earliest.
module f_max_scatter #(
    parameter int DATA_W  = 32,
    parameter int DELAY_W = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               running,
    input  logic [DELAY_W-1:0] strideMinusOne,
    input  logic [DELAY_W-1:0] delay0,
    input  logic [DATA_W-1:0]  in0,
    input  logic [DATA_W-1:0]  in1,
    output logic [DATA_W-1:0]  out0
);

    // Sign-magnitude "greater than" on the IEEE-754 bit layout.
    // +0 beats -0 because the sign bits differ. NaN is ordered by raw bits.
    function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (a[DATA_W-1] != b[DATA_W-1])
            return ~a[DATA_W-1];
        else if (!a[DATA_W-1])
            return a[DATA_W-2:0] > b[DATA_W-2:0];
        else
            return a[DATA_W-2:0] < b[DATA_W-2:0];
    endfunction

    // Capture compare: strict for earliest-index ties, inclusive for latest.
    function automatic logic take_new(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
`ifdef F_MAX_SCATTER_TIE_LAST_EN
        return gt(a, b) || (a == b);
`else
        return gt(a, b);
`endif
    endfunction

    logic [DELAY_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]  max_val_q, max_val_d;
    logic [DELAY_W-1:0] max_idx_q, max_idx_d;
    logic [DELAY_W-1:0] win_idx_q, win_idx_d;
    logic [DELAY_W-1:0] pos_q, pos_d;
    logic               captured_q, captured_d;
    logic               has_win_q, has_win_d;
    logic [DATA_W-1:0]  out0_q, out0_d;

    logic               first;
    logic [DELAY_W-1:0] sel_idx;
    logic [DELAY_W-1:0] cur_pos;
    logic               has_win_eff;

    assign first       = (cnt_q == '0);
    // On a window boundary, the argmax just completed is still in max_idx_q.
    assign sel_idx     = first ? max_idx_q : win_idx_q;
    assign cur_pos     = first ? '0 : pos_q;
    assign has_win_eff = first ? captured_q : has_win_q;
    assign out0        = out0_q;

    // Delay/stride counter. It runs regardless of running; run reloads it.
    always_comb begin
        cnt_d = cnt_q;
        if (run)
            cnt_d = delay0;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
        else
            cnt_d = strideMinusOne;
    end

    // Window capture, boundary hand-off and scatter. History clear on run wins.
    always_comb begin
        max_val_d  = max_val_q;
        max_idx_d  = max_idx_q;
        win_idx_d  = win_idx_q;
        pos_d      = pos_q;
        captured_d = captured_q;
        has_win_d  = has_win_q;
        out0_d     = out0_q;
        if (run) begin
            captured_d = 1'b0;
            has_win_d  = 1'b0;
            pos_d      = '0;
            if (running)
                out0_d = '0;
        end else if (running) begin
            if (first) begin
                max_val_d  = in0;
                max_idx_d  = '0;
                pos_d      = {{(DELAY_W-1){1'b0}}, 1'b1};
                captured_d = 1'b1;
                win_idx_d  = max_idx_q;
                has_win_d  = captured_q;
            end else begin
                if (take_new(in0, max_val_q)) begin
                    max_val_d = in0;
                    max_idx_d = pos_q;
                end
                pos_d = pos_q + 1'b1;
            end
            out0_d = (has_win_eff && (cur_pos == sel_idx)) ? in1 : '0;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            max_val_q  <= '0;
            max_idx_q  <= '0;
            win_idx_q  <= '0;
            pos_q      <= '0;
            captured_q <= 1'b0;
            has_win_q  <= 1'b0;
            out0_q     <= '0;
        end else begin
            cnt_q      <= cnt_d;
            max_val_q  <= max_val_d;
            max_idx_q  <= max_idx_d;
            win_idx_q  <= win_idx_d;
            pos_q      <= pos_d;
            captured_q <= captured_d;
            has_win_q  <= has_win_d;
            out0_q     <= out0_d;
        end
    end

endmodule
